// File: rtl/button_debounce_multi.sv
// button_debounce_multi: per-channel synchronizer, debouncer, press/release pulses and optional auto-repeat.
// Auto-repeat FSMs exist only when BUTTON_AUTO_REPEAT_EN is defined; otherwise repeat_pulse is tied to 0.
module button_debounce_multi #(
    parameter int N_CH          = 5,
    parameter int DEB_CYCLES    = 100000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] but_in,
    output logic [N_CH-1:0] but_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    if (N_CH < 1 || N_CH > 32 || DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("button_debounce_multi: parameter out of range");
    end

    logic [N_CH-1:0] meta_q, sync_q, out_q, out_d, press_q, press_d, rel_q, rel_d;
    logic [DW-1:0]   dcnt_q [N_CH];
    logic [DW-1:0]   dcnt_d [N_CH];

    // Counter runs only while the synchronized level disagrees with the accepted level.
    always_comb begin
        out_d   = out_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            dcnt_d[i] = '0;
            if (sync_q[i] != out_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    out_d[i]   = sync_q[i];
                    press_d[i] = sync_q[i];
                    rel_d[i]   = ~sync_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= '0;
            sync_q  <= '0;
            out_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < N_CH; i++) dcnt_q[i] <= '0;
        end else begin
            meta_q  <= but_in;
            sync_q  <= meta_q;
            out_q   <= out_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            for (int i = 0; i < N_CH; i++) dcnt_q[i] <= dcnt_d[i];
        end
    end

    assign but_out       = out_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;

    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    rpt_state_e      st_q   [N_CH];
    rpt_state_e      st_d   [N_CH];
    logic [RW-1:0]   rcnt_q [N_CH];
    logic [RW-1:0]   rcnt_d [N_CH];
    logic [N_CH-1:0] rpt;

    // Leaving on the falling debounced edge keeps the release cycle itself in IDLE, so no pulse there.
    always_comb begin
        rpt = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_d[i]   = st_q[i];
            rcnt_d[i] = rcnt_q[i] + 1'b1;
            case (st_q[i])
                IDLE: begin
                    rcnt_d[i] = '0;
                    st_d[i]   = press_q[i] ? HOLD : IDLE;
                end
                HOLD: begin
                    if (rcnt_q[i] == HOLD_LAST) begin
                        st_d[i]   = REPEAT;
                        rcnt_d[i] = '0;
                        rpt[i]    = 1'b1;
                    end
                end
                REPEAT: begin
                    if (rcnt_q[i] == REP_LAST) begin
                        rcnt_d[i] = '0;
                        rpt[i]    = 1'b1;
                    end
                end
                default: begin
                    st_d[i]   = IDLE;
                    rcnt_d[i] = '0;
                end
            endcase
            if (rel_d[i]) begin
                st_d[i]   = IDLE;
                rcnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]   <= IDLE;
                rcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]   <= st_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    assign repeat_pulse = rpt;
`else
    assign repeat_pulse = '0;
`endif
endmodule

// File: tb/tb_button_debounce_multi.sv
// tb_button_debounce_multi: directed and random stimulus checked against a sliding-window reference model.
module tb_button_debounce_multi;
    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] but_in;
    logic [N-1:0] but_out, press_pulse, release_pulse, repeat_pulse;

    button_debounce_multi #(
        .N_CH(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .but_in(but_in), .but_out(but_out),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: input history newest-first; index j holds the level sampled j edges ago.
    logic [N-1:0] hq[$];
    logic [N-1:0] m_out, m_press, m_rel, m_rpt;
    int           press_cyc [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        repeat (DEB + 2) hq.push_back('0);
        m_out = '0; m_press = '0; m_rel = '0; m_rpt = '0;
        for (int c = 0; c < N; c++) press_cyc[c] = 0;
    endtask

    task automatic model_update();
        bit all_diff;
        int k;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hq.push_front(but_in);
        void'(hq.pop_back());
        m_press = '0; m_rel = '0; m_rpt = '0;
        for (int c = 0; c < N; c++) begin
            // The synchronizer delays by two edges; accept when the last DEB synchronized samples all disagree.
            all_diff = 1'b1;
            for (int j = 2; j < DEB + 2; j++) if (hq[j][c] == m_out[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_out[c] = ~m_out[c];
                if (m_out[c]) begin
                    m_press[c]   = 1'b1;
                    press_cyc[c] = cyc;
                end else m_rel[c] = 1'b1;
            end
`ifdef BUTTON_AUTO_REPEAT_EN
            k = cyc - press_cyc[c];
            if (m_out[c] && (k == HOLD || (k > HOLD && (k - HOLD) % REP == 0))) m_rpt[c] = 1'b1;
`else
            k = 0;
`endif
        end
    endtask

    task automatic compare_all(input string sfx);
        check({"but_out", sfx}, 32'(but_out), 32'(m_out));
        check({"press", sfx}, 32'(press_pulse), 32'(m_press));
        check({"release", sfx}, 32'(release_pulse), 32'(m_rel));
        check({"repeat", sfx}, 32'(repeat_pulse), 32'(m_rpt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all("");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic latency(input string tag, input int ch, input int exp);
        int n;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (press_pulse[ch]) n = i;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    int rem [N];

    initial begin
        rst_n  = 1'b0;
        but_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("_reset");
        rst_n = 1'b1;
        ticks(3);

        but_in[0] = 1'b1;
        latency("lat_ch0", 0, DEB + 2);
        ticks(5);

        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) but_in[1] = ~but_in[1];
            tick();
            check("bounce_out1", 32'(but_out[1]), 32'd0);
        end
        but_in[1] = 1'b0;
        ticks(8);

        but_in[2] = 1'b1;
        ticks(DEB + 2 + 40);
        but_in[2] = 1'b0;
        ticks(12);

        but_in[0] = 1'b0;
        ticks(10);
        but_in[0] = 1'b1;
        but_in[3] = 1'b1;
        ticks(DEB + 1);
        tick();
        check("simul_press", 32'(press_pulse), 32'b1001);

        but_in[2] = 1'b1;
        ticks(DEB + 2 + 12);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("_async_rst");
        @(negedge clk);
        ticks(2);
        rst_n = 1'b1;
        latency("lat_after_rst", 2, DEB + 2);
        ticks(30);

        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 30);
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    but_in[c] = ~but_in[c];
                    rem[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 30));
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
